// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and rotation helper for the N-channel interrupt core
package pic_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK1 = 1'b1
   } state_t;

   typedef struct packed {
      logic        rotate_en;
      logic        aeoi;
      logic [31:0] vector_base;
   } pic_cfg_t;

   // Rotate the low n bits of vec left by amount (amount may equal n); bits at and above n read as zero.
   function automatic logic [31:0] rotl_n(input logic [31:0] vec, input logic [31:0] amount,
                                          input logic [31:0] n);
      logic [31:0] mask;
      logic [31:0] amt;
      logic [31:0] v;
      mask = (n >= 32'd32) ? '1 : ((32'd1 << n) - 32'd1);
      amt  = (amount >= n) ? amount - n : amount;
      v    = vec & mask;
      return ((v << amt) | (v >> (n - amt))) & mask;
   endfunction

endpackage

// File: rtl/pic_prio_n.sv
// rtl/pic_prio_n.sv - priority resolver: rotate, find-first-set, un-rotate
module pic_prio_n
   import pic_pkg::*;
#(
   parameter  int N   = 8,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] rot_ptr,
   output logic           found,
   output logic [IDW-1:0] id
);

   localparam logic [IDW:0] N_W = (IDW+1)'(N);

   logic [IDW-1:0] start;
   logic [IDW-1:0] pos;
   logic [N-1:0]   rot;
   logic [IDW:0]   sum;

   // Bit 0 of rot is the channel just after rot_ptr, i.e. the highest-priority one.
   always_comb begin
      start = (rot_ptr == IDW'(N-1)) ? '0 : rot_ptr + 1'b1;
      rot   = N'(rotl_n(32'(req), 32'(N) - 32'(start), 32'(N)));
      found = 1'b0;
      pos   = '0;
      for (int j = N-1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            pos   = IDW'(j);
         end
      end
      sum = {1'b0, pos} + {1'b0, start};
      id  = (sum >= N_W) ? IDW'(sum - N_W) : sum[IDW-1:0];
   end

endmodule

// File: rtl/pic_core_n.sv
// rtl/pic_core_n.sv - N-channel 8259-style interrupt core: IRR/ISR/IMR, priority, INTA sequencer
module pic_core_n
   import pic_pkg::*;
#(
   parameter  int N   = 8,
   parameter  int VW  = 8,
   localparam int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   irq_in,
   input  logic [N-1:0]   trig_level,
   input  logic [N-1:0]   imr,
   input  logic           rotate_en,
   input  logic           aeoi,
   input  logic [VW-1:0]  vector_base,
   input  logic           inta,
   input  logic           eoi,
   input  logic           eoi_specific,
   input  logic [IDW-1:0] eoi_id,
   output logic           int_out,
   output logic [VW-1:0]  vector_out,
   output logic           vector_valid,
   output logic [N-1:0]   irr_out,
   output logic [N-1:0]   isr_out
);

   localparam logic [IDW-1:0] LAST_ID = IDW'(N-1);
   localparam logic [IDW:0]   N_W     = (IDW+1)'(N);

   pic_cfg_t       cfg;
   state_t         state_q, state_d;
   logic [N-1:0]   irr_q, irr_d, isr_q, isr_d, irq_prev_q, irq_prev_d;
   logic [IDW-1:0] rot_ptr_q, rot_ptr_d, sel_id_q, sel_id_d;
   logic           spur_q, spur_d, int_out_q, int_out_d, vector_valid_q, vector_valid_d;
   logic [VW-1:0]  vector_out_q, vector_out_d;

   logic [IDW-1:0] ptr_eff, start, cand_id, isr_hi_id, eoi_tgt;
   logic           cand_found, isr_found, eligible, eoi_hit;
   logic [N-1:0]   req_vec, edge_set, irr_clr;

   function automatic logic [IDW-1:0] rank(input logic [IDW-1:0] ch, input logic [IDW-1:0] st);
      logic [IDW:0] diff;
      diff = (ch >= st) ? {1'b0, ch} - {1'b0, st} : {1'b0, ch} + N_W - {1'b0, st};
      return diff[IDW-1:0];
   endfunction

   assign cfg      = '{rotate_en: rotate_en, aeoi: aeoi, vector_base: 32'(vector_base)};
   assign ptr_eff  = cfg.rotate_en ? rot_ptr_q : LAST_ID;
   assign start    = (ptr_eff == LAST_ID) ? '0 : ptr_eff + 1'b1;
   assign req_vec  = irr_q & ~imr;
   assign edge_set = irq_in & ~irq_prev_q;

   pic_prio_n #(.N(N)) u_irr_prio (
      .req     (req_vec),
      .rot_ptr (ptr_eff),
      .found   (cand_found),
      .id      (cand_id)
   );

   pic_prio_n #(.N(N)) u_isr_prio (
      .req     (isr_q),
      .rot_ptr (ptr_eff),
      .found   (isr_found),
      .id      (isr_hi_id)
   );

   assign eligible = cand_found && (!isr_found || (rank(cand_id, start) < rank(isr_hi_id, start)));
   assign eoi_tgt  = eoi_specific ? eoi_id : isr_hi_id;
   assign eoi_hit  = eoi && (eoi_specific ? (({1'b0, eoi_id} < N_W) && isr_q[eoi_id]) : isr_found);

   always_comb begin
      state_d        = state_q;
      sel_id_d       = sel_id_q;
      spur_d         = spur_q;
      isr_d          = isr_q;
      rot_ptr_d      = rot_ptr_q;
      irr_clr        = '0;
      irq_prev_d     = irq_in;
      int_out_d      = (state_q == IDLE) && eligible;
      vector_valid_d = 1'b0;
      vector_out_d   = vector_out_q;

      case (state_q)
         IDLE: begin
            if (inta) begin
               state_d           = ACK1;
               spur_d            = !eligible;
               sel_id_d          = eligible ? cand_id : LAST_ID;
               irr_clr[sel_id_d] = 1'b1;
            end
         end
         ACK1: begin
            if (inta) begin
               state_d        = IDLE;
               vector_out_d   = VW'(cfg.vector_base + 32'(sel_id_q));
               vector_valid_d = 1'b1;
               if (cfg.aeoi && !spur_q) begin
                  isr_d[sel_id_q] = 1'b0;
                  if (cfg.rotate_en) rot_ptr_d = sel_id_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // An explicit EOI overrides an AEOI rotation landing in the same cycle.
      if (eoi_hit) begin
         isr_d[eoi_tgt] = 1'b0;
         if (cfg.rotate_en) rot_ptr_d = eoi_tgt;
      end
      if ((state_q == IDLE) && inta && eligible) isr_d[sel_id_d] = 1'b1;

      irr_d = (trig_level & irq_in) | (~trig_level & ((irr_q & ~irr_clr) | edge_set));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         irr_q          <= '0;
         isr_q          <= '0;
         irq_prev_q     <= '0;
         rot_ptr_q      <= LAST_ID;
         sel_id_q       <= '0;
         spur_q         <= 1'b0;
         int_out_q      <= 1'b0;
         vector_valid_q <= 1'b0;
         vector_out_q   <= '0;
      end else begin
         state_q        <= state_d;
         irr_q          <= irr_d;
         isr_q          <= isr_d;
         irq_prev_q     <= irq_prev_d;
         rot_ptr_q      <= rot_ptr_d;
         sel_id_q       <= sel_id_d;
         spur_q         <= spur_d;
         int_out_q      <= int_out_d;
         vector_valid_q <= vector_valid_d;
         vector_out_q   <= vector_out_d;
      end
   end

   assign int_out      = int_out_q;
   assign vector_out   = vector_out_q;
   assign vector_valid = vector_valid_q;
   assign irr_out      = irr_q;
   assign isr_out      = isr_q;

endmodule

// File: tb/tb_pic_core_n.sv
// tb/tb_pic_core_n.sv - scoreboard bench for pic_core_n with a behavioural reference model
module tb_pic_core_n;

   localparam int N = 8;

   logic       clk, rst;
   logic [7:0] irq_in, trig_level, imr, vector_base, vector_out, irr_out, isr_out;
   logic       rotate_en, aeoi, inta, eoi, eoi_specific, int_out, vector_valid;
   logic [2:0] eoi_id;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] last_vec;

   bit [N-1:0] irr_m, isr_m, prev_m;
   int         rot_m, sel_m;
   bit         ack_m, spur_m, int_m;

   pic_core_n #(.N(N), .VW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .irq_in       (irq_in),
      .trig_level   (trig_level),
      .imr          (imr),
      .rotate_en    (rotate_en),
      .aeoi         (aeoi),
      .vector_base  (vector_base),
      .inta         (inta),
      .eoi          (eoi),
      .eoi_specific (eoi_specific),
      .eoi_id       (eoi_id),
      .int_out      (int_out),
      .vector_out   (vector_out),
      .vector_valid (vector_valid),
      .irr_out      (irr_out),
      .isr_out      (isr_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      irr_m = '0; isr_m = '0; prev_m = '0;
      rot_m = N-1; sel_m = 0;
      ack_m = 0; spur_m = 0; int_m = 0;
   endtask

   // One clock of the interrupt controller, from the rules in plain terms.
   task automatic model_step();
      int top, cand, ihi, ck, ik, tgt, sel, ch, rot_n;
      bit elig, sp;
      bit [N-1:0] irr_n, isr_n, edges;
      top  = rotate_en ? (rot_m + 1) % N : 0;
      cand = -1; ihi = -1; ck = N; ik = N;
      for (int k = 0; k < N; k++) begin
         ch = (top + k) % N;
         if (cand < 0 && irr_m[ch] && !imr[ch]) begin cand = ch; ck = k; end
         if (ihi < 0 && isr_m[ch]) begin ihi = ch; ik = k; end
      end
      elig  = (cand >= 0) && (ck < ik);
      edges = irq_in & ~prev_m;
      for (int i = 0; i < N; i++)
         irr_n[i] = trig_level[i] ? irq_in[i] : (irr_m[i] | edges[i]);
      isr_n = isr_m;
      rot_n = rot_m;
      if (ack_m && inta) begin
         exp_q.push_back(8'(vector_base + 8'(sel_m)));
         if (aeoi && !spur_m) begin
            isr_n[sel_m] = 1'b0;
            if (rotate_en) rot_n = sel_m;
         end
      end
      if (eoi) begin
         tgt = eoi_specific ? int'(eoi_id) : ihi;
         if (tgt >= 0 && tgt < N && isr_m[tgt]) begin
            isr_n[tgt] = 1'b0;
            if (rotate_en) rot_n = tgt;
         end
      end
      if (!ack_m && inta) begin
         sp  = !elig;
         sel = elig ? cand : N-1;
         if (!trig_level[sel]) irr_n[sel] = edges[sel];
         if (!sp) isr_n[sel] = 1'b1;
         spur_m = sp;
         sel_m  = sel;
      end
      int_m  = !ack_m && elig;
      if (inta) ack_m = !ack_m;
      irr_m  = irr_n;
      isr_m  = isr_n;
      rot_m  = rot_n;
      prev_m = irq_in;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("irr", irr_out, irr_m);
      check("isr", isr_out, isr_m);
      check("int_out", int_out, int_m);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ack();
      inta = 1'b1; tick();
      inta = 1'b0; tick();
      inta = 1'b1; tick();
      inta = 1'b0; tick();
   endtask

   task automatic do_eoi(input bit specific, input int id);
      eoi = 1'b1; eoi_specific = specific; eoi_id = 3'(id);
      tick();
      eoi = 1'b0; eoi_specific = 1'b0;
   endtask

   // Monitor: every vector pulse must match the head of the expected queue.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (vector_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("vector_unexpected", 32'(vector_out), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("vector", 32'(vector_out), 32'(e));
            end
            last_vec = vector_out;
         end
      end
   end

   initial begin
      rst = 1'b1; irq_in = '0; trig_level = '0; imr = '0; rotate_en = 1'b0; aeoi = 1'b0;
      vector_base = 8'h20; inta = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; eoi_id = '0;
      last_vec = '0;
      model_reset();
      #12;
      check("rst_int", int_out, 0);
      check("rst_vv", vector_valid, 0);
      check("rst_vo", vector_out, 0);
      check("rst_irr", irr_out, 0);
      check("rst_isr", isr_out, 0);
      rst = 1'b0;

      // Fixed priority, edge channel 3
      irq_in = 8'h08; ticks(2);
      check("ch3_int", int_out, 1);
      ack();
      check("ch3_vec", last_vec, 8'h23);
      check("ch3_isr", isr_out, 8'h08);
      check("ch3_irr", irr_out, 8'h00);

      // Nesting: 5 is blocked by in-service 3, 1 preempts
      irq_in = 8'h28; ticks(3);
      check("nest5_int", int_out, 0);
      irq_in = 8'h2A; ticks(2);
      check("nest1_int", int_out, 1);
      ack();
      check("nest1_vec", last_vec, 8'h21);
      check("nest1_isr", isr_out, 8'h0A);
      check("nest1_irr", irr_out, 8'h20);
      do_eoi(1, 1);
      do_eoi(0, 0);
      check("eoi_isr", isr_out, 8'h00);
      ticks(2);
      ack();
      check("ch5_vec", last_vec, 8'h25);
      do_eoi(0, 0);
      irq_in = '0; ticks(2);

      // Rotating priority
      rotate_en = 1'b1;
      irq_in = 8'h04; ticks(2);
      ack();
      check("rot2_vec", last_vec, 8'h22);
      do_eoi(0, 0);
      irq_in = 8'h16; ticks(2);
      ack();
      check("rot4_vec", last_vec, 8'h24);
      do_eoi(0, 0);
      ticks(2);
      ack();
      check("rot1_vec", last_vec, 8'h21);
      do_eoi(0, 0);
      irq_in = '0; rotate_en = 1'b0; ticks(2);

      // Spurious: level channel 6 drops before the first inta
      trig_level = 8'h40; irq_in = 8'h40; ticks(3);
      check("lvl6_int", int_out, 1);
      irq_in = '0; tick();
      ack();
      check("spur_vec", last_vec, 8'h27);
      check("spur_isr", isr_out, 8'h00);
      trig_level = '0; ticks(2);

      // AEOI with vector wrap
      aeoi = 1'b1; vector_base = 8'hFE; irq_in = 8'h20; ticks(2);
      ack();
      check("aeoi_vec", last_vec, 8'h03);
      check("aeoi_isr", isr_out, 8'h00);
      aeoi = 1'b0; vector_base = 8'h20; irq_in = '0; ticks(2);

      // Asynchronous reset while in ACK1 with an edge pending
      irq_in = 8'h04; ticks(2);
      inta = 1'b1; tick(); inta = 1'b0;
      irq_in = 8'h14; tick();
      check("pend_irr", irr_out, 8'h10);
      #2 rst = 1'b1;
      #1;
      check("arst_int", int_out, 0);
      check("arst_vv", vector_valid, 0);
      check("arst_vo", vector_out, 0);
      check("arst_irr", irr_out, 0);
      check("arst_isr", isr_out, 0);
      model_reset();
      irq_in = '0;
      #2 rst = 1'b0;
      tick();
      ack();
      check("post_rst_vec", last_vec, 8'h27);

      // Randomized traffic against the model
      for (int blk = 0; blk < 8; blk++) begin
         trig_level  = 8'($urandom);
         rotate_en   = 1'($urandom);
         aeoi        = 1'($urandom);
         vector_base = 8'($urandom);
         imr         = 8'($urandom & $urandom);
         for (int c = 0; c < 250; c++) begin
            irq_in ^= 8'($urandom & $urandom & $urandom);
            if ($urandom_range(31) == 0) imr = 8'($urandom & $urandom);
            inta         = ($urandom_range(5) == 0);
            eoi          = !inta && ($urandom_range(4) == 0);
            eoi_specific = 1'($urandom);
            eoi_id       = 3'($urandom);
            tick();
         end
         inta = 1'b0; eoi = 1'b0;
      end
      ticks(3);
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
